// File: rtl/mlp_param_loader.sv
// -----------------------------------------------------------------------------
// mlp_param_loader
//
// Upstream feeder for the XOR MLP core. A byte-serial parameter stream
// (valid/ready) fills a shadow bank. The block checks the frame length and the
// gaps between bytes. A complete frame waits in PENDING until the MLP raises
// commit_en. The whole bank is then copied to the active outputs in one step.
//
// Byte order in a frame (index 0..N_PARAMS-1, default 13):
//   hw1, hw2, hb1, hw3, hw4, hb2, hw5, hw6, hb3, ow1, ow2, ow3, ob
//
// Ports
//   clk          in   1           clock; all logic on the rising edge
//   reset        in   1           asynchronous, active-low reset
//   s_data       in   8           parameter byte (two's complement)
//   s_valid      in   1           s_data is valid
//   s_last       in   1           s_data is the last byte of the frame
//   s_ready      out  1           loader accepts a byte this cycle
//   abort        in   1           drop any partial or pending frame
//   commit_en    in   1           MLP can take new parameters this cycle
//   params       out  8*N_PARAMS  active bank; byte i at [8*i+7:8*i]
//   params_valid out  1           active bank holds a committed frame
//   loaded       out  1           1-cycle pulse in the cycle after a commit
//   err_len      out  1           1-cycle pulse: frame length was wrong
//   err_timeout  out  1           1-cycle pulse: gap between bytes too long
// -----------------------------------------------------------------------------
module mlp_param_loader #(
  parameter int N_PARAMS = 13,
  parameter int TIMEOUT  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic                  abort,
  input  logic                  commit_en,
  output logic [8*N_PARAMS-1:0] params,
  output logic                  params_valid,
  output logic                  loaded,
  output logic                  err_len,
  output logic                  err_timeout
);

  localparam int IDX_W = $clog2(N_PARAMS);
  localparam int GAP_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PARAMS - 1);
  // The gap counter holds the number of idle cycles seen so far. An idle
  // cycle when it already holds TIMEOUT-1 is the TIMEOUT-th one.
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    DRAIN   = 2'd2,
    PENDING = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic [8*N_PARAMS-1:0]   shadow_q, shadow_d;
  logic [8*N_PARAMS-1:0]   params_q, params_d;
  logic                    params_valid_q, params_valid_d;
  logic                    loaded_q, loaded_d;
  logic                    err_len_q, err_len_d;
  logic                    err_timeout_q, err_timeout_d;
  logic                    accept;

  // Gating with reset keeps s_ready low for the whole time reset is held,
  // not only from the first clock edge.
  assign s_ready = reset && (state_q != PENDING);
  assign accept  = s_valid && s_ready;

  // NOTE: every signal gets a default before the case statement. This
  // prevents latch inference when a branch does not assign a signal.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    gap_d          = gap_q;
    shadow_d       = shadow_q;
    params_d       = params_q;
    params_valid_d = params_valid_q;
    loaded_d       = 1'b0;
    err_len_d      = 1'b0;
    err_timeout_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // While in IDLE, abort only drops a byte that arrives in the same cycle.
        if (accept && !abort) begin
          shadow_d[7:0] = s_data;
          gap_d         = '0;
          if (s_last) begin
            err_len_d = 1'b1;
            idx_d     = '0;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          gap_d   = '0;
        end else if (accept) begin
          shadow_d[8*idx_q +: 8] = s_data;
          gap_d                  = '0;
          idx_d                  = idx_q + 1'b1;
          if (s_last) begin
            idx_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = PENDING;
            end else begin
              err_len_d = 1'b1;
              state_d   = IDLE;
            end
          end else if (idx_q == LAST_IDX) begin
            // The frame is full but did not end. Drop bytes up to the next s_last.
            err_len_d = 1'b1;
            idx_d     = '0;
            state_d   = DRAIN;
          end
        end else if (gap_q == GAP_LIMIT) begin
          err_timeout_d = 1'b1;
          idx_d         = '0;
          gap_d         = '0;
          state_d       = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      DRAIN: begin
        if (abort || (accept && s_last)) begin
          state_d = IDLE;
        end
      end

      PENDING: begin
        // abort wins over commit_en when both are high.
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          gap_d   = '0;
        end else if (commit_en) begin
          params_d       = shadow_q;
          params_valid_d = 1'b1;
          loaded_d       = 1'b1;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      gap_q          <= '0;
      // NOTE: the shadow bank is reset like the other registers. It is only
      // 13 bytes, and clearing it gives a known value after reset.
      shadow_q       <= '0;
      params_q       <= '0;
      params_valid_q <= 1'b0;
      loaded_q       <= 1'b0;
      err_len_q      <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      gap_q          <= gap_d;
      shadow_q       <= shadow_d;
      params_q       <= params_d;
      params_valid_q <= params_valid_d;
      loaded_q       <= loaded_d;
      err_len_q      <= err_len_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign params       = params_q;
  assign params_valid = params_valid_q;
  assign loaded       = loaded_q;
  assign err_len      = err_len_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_mlp_param_loader.sv
// -----------------------------------------------------------------------------
// tb_mlp_param_loader
//
// Self-checking bench for mlp_param_loader. Inputs change 1 time unit after
// each rising edge. Outputs are read at that same point, after the edge has
// updated them. Pulse counters run on the falling edge. The reference works
// at frame level. Each frame type (good, short, long, stalled, aborted) sets
// the expected bank and the expected number of loaded/err_len/err_timeout
// pulses.
// -----------------------------------------------------------------------------
module tb_mlp_param_loader;

  localparam int N  = 13;
  localparam int TO = 64;
  localparam int PW = 8 * N;

  logic          clk;
  logic          reset;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_last;
  logic          s_ready;
  logic          abort;
  logic          commit_en;
  logic [PW-1:0] params;
  logic          params_valid;
  logic          loaded;
  logic          err_len;
  logic          err_timeout;

  int checks = 0;
  int errors = 0;
  int n_loaded = 0;
  int n_err_len = 0;
  int n_err_to = 0;

  // Expected active bank.
  logic [PW-1:0] exp_params;
  logic          exp_valid;

  mlp_param_loader #(.N_PARAMS(N), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .abort        (abort),
    .commit_en    (commit_en),
    .params       (params),
    .params_valid (params_valid),
    .loaded       (loaded),
    .err_len      (err_len),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses cycle by cycle. A pulse that lasts two cycles counts twice.
  always @(negedge clk) begin
    if (loaded === 1'b1)      n_loaded++;
    if (err_len === 1'b1)     n_err_len++;
    if (err_timeout === 1'b1) n_err_to++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    cycle();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic make_frame(output logic [PW-1:0] f);
    for (int i = 0; i < N; i++) f[8*i +: 8] = 8'($urandom);
  endtask

  task automatic send_frame(input logic [PW-1:0] f);
    for (int i = 0; i < N; i++) send_byte(f[8*i +: 8], i == N - 1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    abort = 1'b0; commit_en = 1'b0;
    exp_params = '0; exp_valid = 1'b0;
    idle(3);
    checks++;
    if (s_ready !== 1'b0) begin
      errors++; $display("FAIL reset_s_ready: got %b expected 0", s_ready);
    end
    checks++;
    if (params !== '0) begin
      errors++; $display("FAIL reset_params: got %h expected 0", params);
    end
    checks++;
    if ({params_valid, loaded, err_len, err_timeout} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000",
               {params_valid, loaded, err_len, err_timeout});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b expected 1", s_ready);
    end
    cycle();
  endtask

  // Bytes 0x01..0x0D sent back to back with commit_en held high.
  task automatic test_basic();
    int l0;
    logic [PW-1:0] expv;
    expv = 104'h0D0C0B0A090807060504030201;
    l0 = n_loaded;
    commit_en = 1'b1;
    for (int i = 0; i < N; i++) send_byte(8'(i + 1), i == N - 1);
    checks++;
    if (s_ready !== 1'b0 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL basic_pending: got ready=%b loaded=%b expected 0 0", s_ready, loaded);
    end
    cycle();
    checks++;
    if (params !== expv || params_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_commit: got %h v=%b expected %h v=1", params, params_valid, expv);
    end
    checks++;
    if (loaded !== 1'b1 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_loaded: got loaded=%b ready=%b expected 1 1", loaded, s_ready);
    end
    commit_en = 1'b0;
    cycle();
    checks++;
    if (loaded !== 1'b0 || n_loaded - l0 != 1) begin
      errors++;
      $display("FAIL basic_loaded_width: got loaded=%b count=%0d expected 0 1",
               loaded, n_loaded - l0);
    end
    exp_params = expv; exp_valid = 1'b1;
  endtask

  // A full frame waits 20 cycles for commit_en, then commits.
  task automatic test_commit_hold();
    logic [PW-1:0] f;
    make_frame(f);
    commit_en = 1'b0;
    send_frame(f);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (s_ready !== 1'b0 || params !== exp_params) begin
        errors++;
        $display("FAIL hold_cycle%0d: got ready=%b params=%h expected 0 %h",
                 i, s_ready, params, exp_params);
      end
      cycle();
    end
    commit_en = 1'b1;
    cycle();
    commit_en = 1'b0;
    checks++;
    if (params !== f || loaded !== 1'b1) begin
      errors++;
      $display("FAIL hold_commit: got %h loaded=%b expected %h 1", params, loaded, f);
    end
    exp_params = f; exp_valid = 1'b1;
    cycle();
  endtask

  // s_last on byte 5 gives err_len. The next full frame still commits.
  task automatic test_short();
    int e0;
    logic [PW-1:0] f;
    e0 = n_err_len;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), i == 4);
    checks++;
    if (err_len !== 1'b1) begin
      errors++; $display("FAIL short_err_len: got %b expected 1", err_len);
    end
    cycle();
    checks++;
    if (err_len !== 1'b0 || params !== exp_params) begin
      errors++;
      $display("FAIL short_after: got err=%b params=%h expected 0 %h", err_len, params, exp_params);
    end
    make_frame(f);
    commit_en = 1'b1;
    send_frame(f);
    cycle();
    commit_en = 1'b0;
    checks++;
    if (params !== f || n_err_len - e0 != 1) begin
      errors++;
      $display("FAIL short_recover: got %h errs=%0d expected %h 1", params, n_err_len - e0, f);
    end
    exp_params = f;
    cycle();
  endtask

  // 14 bytes with s_last only on the 14th. err_len follows byte 13.
  task automatic test_long();
    int e0;
    logic [PW-1:0] f;
    e0 = n_err_len;
    for (int i = 0; i < 14; i++) begin
      send_byte(8'($urandom), i == 13);
      if (i == 12) begin
        checks++;
        if (err_len !== 1'b1) begin
          errors++; $display("FAIL long_err_len: got %b expected 1", err_len);
        end
      end
    end
    cycle();
    checks++;
    if (params !== exp_params || n_err_len - e0 != 1) begin
      errors++;
      $display("FAIL long_after: got %h errs=%0d expected %h 1", params, n_err_len - e0, exp_params);
    end
    // The loader is back in IDLE, so a new frame is taken in full.
    make_frame(f);
    commit_en = 1'b1;
    send_frame(f);
    cycle();
    commit_en = 1'b0;
    checks++;
    if (params !== f) begin
      errors++; $display("FAIL long_recover: got %h expected %h", params, f);
    end
    exp_params = f;
    cycle();
  endtask

  // A gap of TO idle cycles times out. A gap of TO-1 does not.
  task automatic test_timeout();
    int t0;
    logic [PW-1:0] f;
    t0 = n_err_to;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0);
    for (int k = 1; k <= TO; k++) begin
      cycle();
      checks++;
      if (err_timeout !== (k == TO)) begin
        errors++;
        $display("FAIL timeout_gap%0d: got %b expected %b", k, err_timeout, (k == TO));
      end
    end
    cycle();
    checks++;
    if (err_timeout !== 1'b0 || params !== exp_params || n_err_to - t0 != 1) begin
      errors++;
      $display("FAIL timeout_after: got err=%b cnt=%0d expected 0 1", err_timeout, n_err_to - t0);
    end
    make_frame(f);
    for (int i = 0; i < 6; i++) send_byte(f[8*i +: 8], 1'b0);
    idle(TO - 1);
    commit_en = 1'b1;
    for (int i = 6; i < N; i++) send_byte(f[8*i +: 8], i == N - 1);
    cycle();
    commit_en = 1'b0;
    checks++;
    if (params !== f || n_err_to - t0 != 1) begin
      errors++;
      $display("FAIL timeout_edge_ok: got %h cnt=%0d expected %h 1", params, n_err_to - t0, f);
    end
    exp_params = f;
    cycle();
  endtask

  task automatic test_abort();
    int l0, e0, t0;
    logic [PW-1:0] f;
    l0 = n_loaded; e0 = n_err_len; t0 = n_err_to;
    make_frame(f);
    commit_en = 1'b0;
    send_frame(f);
    abort = 1'b1; commit_en = 1'b1;
    cycle();
    abort = 1'b0; commit_en = 1'b0;
    checks++;
    if (params !== exp_params || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_pending: got %h ready=%b expected %h 1", params, s_ready, exp_params);
    end
    cycle();
    checks++;
    if (loaded !== 1'b0 || n_loaded != l0) begin
      errors++; $display("FAIL abort_no_loaded: got %0d pulses expected 0", n_loaded - l0);
    end
    // Abort in the middle of LOAD, with a byte offered in the same cycle.
    for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
    abort = 1'b1;
    send_byte(8'hA5, 1'b0);
    abort = 1'b0;
    // Abort in IDLE drops a byte offered with s_last and raises no error.
    abort = 1'b1;
    send_byte(8'h5A, 1'b1);
    abort = 1'b0;
    checks++;
    if (err_len !== 1'b0) begin
      errors++; $display("FAIL abort_idle_drop: got err_len=%b expected 0", err_len);
    end
    make_frame(f);
    commit_en = 1'b1;
    send_frame(f);
    cycle();
    commit_en = 1'b0;
    cycle();
    checks++;
    if (params !== f || n_err_len != e0 || n_err_to != t0) begin
      errors++;
      $display("FAIL abort_recover: got %h errs=%0d/%0d expected %h 0/0",
               params, n_err_len - e0, n_err_to - t0, f);
    end
    exp_params = f;
  endtask

  // Reset asserted between clock edges while a frame is loading.
  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (params !== '0 || {params_valid, loaded, err_len, err_timeout, s_ready} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset: got params=%h flags=%b expected 0 00000",
               params, {params_valid, loaded, err_len, err_timeout, s_ready});
    end
    cycle();
    reset = 1'b1;
    exp_params = '0; exp_valid = 1'b0;
    cycle();
  endtask

  // Random mix of frame types, checked against frame-level expectations.
  task automatic test_random();
    int l0, e0, t0;
    int el, ee, et;
    int kind, len;
    logic [PW-1:0] f;
    l0 = n_loaded; e0 = n_err_len; t0 = n_err_to;
    el = 0; ee = 0; et = 0;
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: begin
          make_frame(f);
          for (int i = 0; i < N; i++) begin
            if (i > 0) idle(int'($urandom_range(0, 2)));
            send_byte(f[8*i +: 8], i == N - 1);
          end
          idle(int'($urandom_range(0, 3)));
          commit_en = 1'b1;
          cycle();
          commit_en = 1'b0;
          exp_params = f; exp_valid = 1'b1; el++;
        end
        1: begin
          len = int'($urandom_range(1, N - 1));
          for (int i = 0; i < len; i++) send_byte(8'($urandom), i == len - 1);
          ee++;
        end
        2: begin
          len = int'($urandom_range(N + 1, N + 3));
          for (int i = 0; i < len; i++) begin
            if (i >= N) idle(int'($urandom_range(0, TO + 4)));
            send_byte(8'($urandom), i == len - 1);
          end
          ee++;
        end
        3: begin
          len = int'($urandom_range(1, N - 1));
          for (int i = 0; i < len; i++) send_byte(8'($urandom), 1'b0);
          idle(TO);
          et++;
        end
        default: begin
          len = int'($urandom_range(1, N - 1));
          for (int i = 0; i < len; i++) send_byte(8'($urandom), 1'b0);
          abort = 1'b1;
          s_valid = 1'($urandom);
          cycle();
          abort = 1'b0;
          s_valid = 1'b0;
        end
      endcase
      idle(2);
      checks++;
      if (params !== exp_params || params_valid !== exp_valid) begin
        errors++;
        $display("FAIL random%0d_bank kind=%0d: got %h v=%b expected %h v=%b",
                 n, kind, params, params_valid, exp_params, exp_valid);
      end
      checks++;
      if (n_loaded - l0 != el || n_err_len - e0 != ee || n_err_to - t0 != et) begin
        errors++;
        $display("FAIL random%0d_pulses kind=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d",
                 n, kind, n_loaded - l0, n_err_len - e0, n_err_to - t0, el, ee, et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_commit_hold();
    test_short();
    test_long();
    test_timeout();
    test_abort();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
